// File: rtl/axilite_apb_mux_bridge.sv
// AXI4-lite slave to multi-slave APB master bridge: one outstanding transfer,
// address-window decode onto N_SLV selects, read/write alternation and ACCESS timeout.
module axilite_apb_mux_bridge #(
  parameter int unsigned AW_AXI  = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW_APB  = 16,
  parameter int unsigned N_SLV   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  axi_clk,
  input  logic                  sys_rst,
  input  logic [AW_AXI-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DW-1:0]         s_wdata,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [AW_AXI-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DW-1:0]         s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [AW_APB-1:0]     m_paddr,
  output logic [N_SLV-1:0]      m_psel,
  output logic                  m_penable,
  output logic                  m_pwrite,
  output logic [DW-1:0]         m_pwdata,
  input  logic [N_SLV*DW-1:0]   m_prdata,
  input  logic [N_SLV-1:0]      m_pready,
  input  logic [N_SLV-1:0]      m_pslverr
);

  localparam int unsigned SW     = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned DEC_HI = AW_APB + SW;
  localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              gnt_q, gnt_d;
  logic              gnt_wr_q, gnt_wr_d;
  logic              prefer_rd_q, prefer_rd_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              arready_q, arready_d;
  logic              bvalid_q, bvalid_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        resp_q, resp_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [N_SLV-1:0]  psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AW_APB-1:0] paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;

  logic [AW_AXI-1:0] req_addr;
  logic [SW-1:0]     dec_sel;
  logic              dec_err;
  logic              wr_elig, rd_elig, pick_wr;
  logic              accept, slv_ready, xfer_done, xfer_tmo, resp_ack;
  logic [DW-1:0]     slv_rdata;

  // Decode the granted channel's address; valids are held until the ready cycle.
  assign req_addr  = gnt_wr_q ? s_awaddr : s_araddr;
  assign dec_sel   = SW'(req_addr >> AW_APB);
  assign dec_err   = ((req_addr >> DEC_HI) != '0) || (32'(dec_sel) >= N_SLV);

  assign wr_elig   = s_awvalid && s_wvalid;
  assign rd_elig   = s_arvalid;
  assign pick_wr   = wr_elig && (!rd_elig || !prefer_rd_q);

  assign accept    = (state_q == IDLE) && gnt_q;
  assign slv_ready = m_pready[sel_q];
  assign slv_rdata = m_prdata[DW*32'(sel_q) +: DW];
  assign xfer_done = (state_q == ACCESS) && slv_ready;
  assign xfer_tmo  = (state_q == ACCESS) && !slv_ready && (TIMEOUT != 0) &&
                     (cnt_q == CW'(TIMEOUT));
  assign resp_ack  = (state_q == RESP) && (gnt_wr_q ? s_bready : s_rready);

  // State register
  always_ff @(posedge axi_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dec_err ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done || xfer_tmo) state_d = RESP;
      RESP:    if (resp_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register
  always_comb begin
    gnt_d       = 1'b0;
    gnt_wr_d    = gnt_wr_q;
    prefer_rd_d = prefer_rd_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    arready_d   = 1'b0;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    resp_d      = resp_q;
    rdata_d     = rdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_q) begin
          if (dec_err) begin
            resp_d   = RESP_DECERR;
            rdata_d  = '0;
            bvalid_d = gnt_wr_q;
            rvalid_d = !gnt_wr_q;
          end else begin
            sel_d    = dec_sel;
            psel_d   = N_SLV'(1) << dec_sel;
            paddr_d  = AW_APB'(req_addr);
            pwrite_d = gnt_wr_q;
            pwdata_d = gnt_wr_q ? s_wdata : '0;
          end
        end else if (wr_elig || rd_elig) begin
          gnt_d       = 1'b1;
          gnt_wr_d    = pick_wr;
          prefer_rd_d = pick_wr;
          awready_d   = pick_wr;
          wready_d    = pick_wr;
          arready_d   = !pick_wr;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = CW'(1);
      end
      ACCESS: begin
        if (xfer_done || xfer_tmo) begin
          psel_d    = '0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          paddr_d   = '0;
          pwdata_d  = '0;
          bvalid_d  = gnt_wr_q;
          rvalid_d  = !gnt_wr_q;
          if (xfer_done) begin
            resp_d  = m_pslverr[sel_q] ? RESP_SLVERR : RESP_OKAY;
            rdata_d = gnt_wr_q ? '0 : slv_rdata;
          end else begin
            resp_d  = RESP_SLVERR;
            rdata_d = '0;
          end
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ack) begin
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge axi_clk) begin
    if (sys_rst) begin
      gnt_q       <= 1'b0;
      gnt_wr_q    <= 1'b0;
      prefer_rd_q <= 1'b1;
      sel_q       <= '0;
      cnt_q       <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      resp_q      <= '0;
      rdata_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_wr_q    <= gnt_wr_d;
      prefer_rd_q <= prefer_rd_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_arready = arready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = resp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;
  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;

endmodule

// File: tb/tb_axilite_apb_mux_bridge.sv
// Self-checking bench for axilite_apb_mux_bridge: directed and random transfers
// compared against a transaction-level expectation model.
module tb_axilite_apb_mux_bridge;

  localparam int unsigned TO = 8;

  logic         axi_clk = 1'b0;
  logic         sys_rst;
  logic [31:0]  s_awaddr, s_wdata, s_araddr, s_rdata;
  logic         s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]   s_bresp, s_rresp;
  logic         s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [11:0]  m_paddr;
  logic [3:0]   m_psel, m_pready, m_pslverr;
  logic         m_penable, m_pwrite;
  logic [31:0]  m_pwdata;
  logic [127:0] m_prdata;

  axilite_apb_mux_bridge #(
    .AW_AXI(32), .DW(32), .AW_APB(12), .N_SLV(4), .TIMEOUT(TO)
  ) dut (
    .axi_clk(axi_clk), .sys_rst(sys_rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 axi_clk = ~axi_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // APB slave behaviour and bus observation, evaluated mid-cycle
  int          wait_cfg = 0;
  int          acc_k, setup_cyc, acc_cyc, pen_viol, stab_viol, ready_viol;
  logic [3:0]  cap_psel;
  logic [11:0] cap_paddr;
  logic        cap_pwrite;
  logic [31:0] cap_pwdata;

  task automatic mon_clear();
    setup_cyc = 0; acc_cyc = 0; acc_k = 0; pen_viol = 0; stab_viol = 0; ready_viol = 0;
    cap_psel = '0; cap_paddr = '0; cap_pwrite = 1'b0; cap_pwdata = '0;
  endtask

  always @(negedge axi_clk) begin
    if (m_penable && m_psel == 4'b0) pen_viol++;
    if ((s_awready || s_wready || s_arready) && (m_psel != 4'b0 || s_bvalid || s_rvalid))
      ready_viol++;
    if (m_psel != 4'b0 && !m_penable) begin
      setup_cyc++;
      acc_k = 0;
      cap_psel = m_psel; cap_paddr = m_paddr; cap_pwrite = m_pwrite; cap_pwdata = m_pwdata;
    end else if (m_psel != 4'b0) begin
      acc_cyc++;
      acc_k++;
      if ({m_psel, m_paddr, m_pwrite, m_pwdata} !== {cap_psel, cap_paddr, cap_pwrite, cap_pwdata})
        stab_viol++;
    end else begin
      acc_k = 0;
    end
    m_pready = (m_psel != 4'b0 && m_penable && acc_k > wait_cfg) ? m_psel : 4'b0;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] all_outs();
    return {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata,
            m_psel, m_penable, m_pwrite, m_paddr, m_pwdata};
  endfunction

  // Transaction-level expectation: window decode, wait count vs timeout, slave mux
  function automatic void model(input bit is_wr, input logic [31:0] addr, input int waits,
                                output logic [1:0] resp, output logic [31:0] rdata,
                                output int acc, output logic [3:0] psel,
                                output logic [11:0] paddr);
    int sel;
    sel   = int'((addr / 32'h1000) % 4);
    paddr = addr[11:0];
    if ((addr / 32'h4000) != 0) begin
      resp = 2'b11; rdata = 0; acc = 0; psel = 4'b0;
    end else begin
      psel = 4'(1 << sel);
      if (waits + 1 <= int'(TO)) begin
        acc   = waits + 1;
        resp  = m_pslverr[sel] ? 2'b10 : 2'b00;
        rdata = is_wr ? 32'h0 : m_prdata[sel*32 +: 32];
      end else begin
        acc = int'(TO); resp = 2'b10; rdata = 0;
      end
    end
  endfunction

  task automatic run_xact(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input int hold, input string tag);
    logic [1:0]  e_resp, h_resp;
    logic [31:0] e_rdata, h_rdata;
    logic [11:0] e_paddr;
    logic [3:0]  e_psel;
    int          e_acc;
    bit          got;
    model(is_wr, addr, waits, e_resp, e_rdata, e_acc, e_psel, e_paddr);
    #1 mon_clear();
    wait_cfg = waits;
    @(negedge axi_clk);
    if (is_wr) begin s_awaddr = addr; s_wdata = wdata; s_awvalid = 1'b1; s_wvalid = 1'b1; end
    else begin s_araddr = addr; s_arvalid = 1'b1; end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge axi_clk);
      if (is_wr ? (s_awready && s_wready && !s_arready) : (s_arready && !s_awready)) got = 1'b1;
    end
    check({tag, "_handshake"}, 128'(got), 128'(1));
    @(posedge axi_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge axi_clk);
      if (is_wr ? s_bvalid : s_rvalid) got = 1'b1;
    end
    check({tag, "_valid"}, 128'(got), 128'(1));
    h_resp  = is_wr ? s_bresp : s_rresp;
    h_rdata = s_rdata;
    for (int c = 0; c < hold; c++) begin
      @(negedge axi_clk);
      check({tag, "_hold"}, {s_bvalid, s_rvalid, h_resp, s_rdata},
            {is_wr, !is_wr, is_wr ? s_bresp : s_rresp, h_rdata});
    end
    check({tag, "_resp"}, 128'(h_resp), 128'(e_resp));
    if (!is_wr) check({tag, "_rdata"}, 128'(h_rdata), 128'(e_rdata));
    if (is_wr) s_bready = 1'b1; else s_rready = 1'b1;
    @(negedge axi_clk);
    s_bready = 1'b0; s_rready = 1'b0;
    check({tag, "_vdrop"}, {s_bvalid, s_rvalid}, 128'(0));
    check({tag, "_setup"}, 128'(setup_cyc), (e_psel != 4'b0) ? 128'(1) : 128'(0));
    check({tag, "_access"}, 128'(acc_cyc), 128'(e_acc));
    check({tag, "_psel"}, 128'(cap_psel), 128'(e_psel));
    if (e_psel != 4'b0)
      check({tag, "_apb"}, {cap_paddr, cap_pwrite, cap_pwdata},
            {e_paddr, is_wr, is_wr ? wdata : 32'h0});
    check({tag, "_proto"}, {32'(pen_viol), 32'(stab_viol), 32'(ready_viol)}, 128'(0));
  endtask

  // Hold both channels valid; each handshake is a new transfer, order must alternate
  task automatic arb_test(input string tag);
    logic [3:0] order;
    int         n;
    order = '0; n = 0;
    #1 mon_clear();
    wait_cfg = 0;
    @(negedge axi_clk);
    s_awaddr = 32'h1000; s_wdata = 32'h5a5a_0001; s_araddr = 32'h2000;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge axi_clk);
      if (s_awready) begin order[n] = 1'b1; n++; end
      else if (s_arready) begin order[n] = 1'b0; n++; end
    end
    @(posedge axi_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    repeat (20) @(negedge axi_clk);
    s_bready = 1'b0; s_rready = 1'b0;
    check({tag, "_grants"}, 128'(n), 128'(4));
    check({tag, "_order"}, 128'(order), 128'(4'b1010));
    check({tag, "_proto"}, {32'(pen_viol), 32'(ready_viol)}, 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r_wr;
    int          r_k, r_sel, r_waits, r_hold;
    logic [31:0] r_addr, r_data;
    int          seen;

    sys_rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m_prdata = '0; m_pslverr = '0; m_pready = '0;
    mon_clear();
    repeat (3) @(negedge axi_clk);
    check("reset_outputs", all_outs(), 128'(0));
    sys_rst = 1'b0;

    arb_test("arb_after_reset");

    m_prdata = {$urandom, $urandom, $urandom, $urandom};
    m_pslverr = 4'b0000;
    run_xact(1'b1, 32'h2010, 32'hDEAD_BEEF, 2, 0, "wr_slv2");

    m_prdata[127:96] = 32'h0000_1234;
    m_pslverr = 4'b1000;
    run_xact(1'b0, 32'h3004, 32'h0, 1, 0, "rd_slv3_err");

    run_xact(1'b0, 32'h0001_0000, 32'h0, 0, 5, "rd_decerr");
    run_xact(1'b1, 32'h0000_4000, 32'h1111_2222, 0, 2, "wr_decerr");

    m_pslverr = 4'b0000;
    run_xact(1'b0, 32'h0000_0FFC, 32'h0, int'(TO) - 1, 0, "rd_last_cycle");
    run_xact(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1000, 0, "wr_timeout");

    for (int i = 0; i < 16; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_k     = int'($urandom_range(0, 5));
      r_sel   = int'($urandom_range(0, 3));
      r_waits = int'($urandom_range(0, 10));
      r_hold  = int'($urandom_range(0, 3));
      r_data  = $urandom;
      if (r_k == 0) r_addr = $urandom | (32'h1 << $urandom_range(14, 31));
      else          r_addr = (32'(r_sel) << 12) | (32'($urandom) & 32'hFFF);
      m_prdata  = {$urandom, $urandom, $urandom, $urandom};
      m_pslverr = 4'($urandom);
      run_xact(r_wr, r_addr, r_data, r_waits, r_hold, "random");
    end

    // Reset while a write is stalled in ACCESS
    #1 mon_clear();
    wait_cfg = 1000;
    @(negedge axi_clk);
    s_awaddr = 32'h1008; s_wdata = 32'h0BAD_0BAD; s_awvalid = 1'b1; s_wvalid = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge axi_clk);
      if (s_awready) seen = 1;
    end
    @(posedge axi_clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge axi_clk);
      if (m_penable) seen = 1;
    end
    repeat (2) @(negedge axi_clk);
    check("midrst_in_access", {m_psel, m_penable}, {4'b0010, 1'b1});
    sys_rst = 1'b1;
    @(negedge axi_clk);
    check("midrst_outputs", all_outs(), 128'(0));
    sys_rst = 1'b0;
    s_bready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge axi_clk);
      if (s_bvalid || m_psel != 4'b0) seen++;
    end
    s_bready = 1'b0;
    check("midrst_no_resp", 128'(seen), 128'(0));

    arb_test("arb_after_midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
